wb_cache_router: RTL and testbench
==================================

Name: wb_cache_router

Overview:
- Routes CPU-side pipelined Wishbone requests to one of two downstream ports: the cachable memory port (C) or the uncached peripheral port (U).
- Classification uses a MEM_ADDR/MEM_MASK compare, the same rule used by the dcache.
- Tracks outstanding transactions and enforces in-order returns; a request to the other port is held until everything outstanding has drained.
- Sits between the ZipCPU memory unit and the dcache / peripheral bus.

Parameters:
- AW, 28, word address width
- DW, 32, data width
- MEM_ADDR, {4'b0100,{(AW-4){1'b0}}}, cachable region base; 0 disables caching (all requests go to U)
- MEM_MASK, {4'b1111,{(AW-4){1'b0}}}, cachable region mask
- LGPEND, 4, log2 of the maximum outstanding requests per burst
- LGTIMEOUT, 10, log2 of the timeout count (used only with the optional feature)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  CPU bus cycle, strobe, write enable
- i_wb_addr  in  AW  CPU address
- i_wb_data  in  DW  CPU write data
- i_wb_sel  in  DW/8  CPU byte selects
- o_wb_stall, o_wb_ack, o_wb_err  out  1 each  CPU stall, ack, bus error
- o_wb_data  out  DW  CPU read data
- o_c_cyc, o_c_stb  out  1 each  C-port cycle and strobe
- o_u_cyc, o_u_stb  out  1 each  U-port cycle and strobe
- o_we  out  1  shared downstream write enable
- o_addr  out  AW  shared downstream address
- o_data  out  DW  shared downstream write data
- o_sel  out  DW/8  shared downstream byte selects
- i_c_stall, i_c_ack, i_c_err  in  1 each  C-port stall, ack, error
- i_c_data  in  DW  C-port read data
- i_u_stall, i_u_ack, i_u_err  in  1 each  U-port stall, ack, error
- i_u_data  in  DW  U-port read data

Behaviour:
- Reset: all outputs 0, state IDLE, pending count 0. Reset applies immediately, including mid-burst; in-flight acks are discarded.
- Classification:
  - cachable = (MEM_ADDR!=0) && ((i_wb_addr & MEM_MASK)==MEM_ADDR).
  - Computed combinationally on the incoming request; all other decisions are registered.
- States:
  - IDLE: no cycle active.
  - CBUS: C-port cycle active.
  - UBUS: U-port cycle active.
  - ABORT: waiting for the CPU to release the cycle after an error.
- Acceptance:
  - A request is accepted when i_wb_stb && !o_wb_stall.
  - Accepted request registers onto o_addr/o_data/o_sel/o_we with selected o_x_stb=1 on the next cycle (1-cycle request latency).
  - o_x_stb holds until !i_x_stall.
- o_wb_stall=1 when any of:
  - the active o_x_stb is held by i_x_stall;
  - pending == 2^LGPEND-1;
  - the request targets the non-active port while pending != 0;
  - state is ABORT.
- Port switch: when pending reaches 0 and the next request targets the other port, the old o_x_cyc drops and the new one rises in the same cycle. Zero-bubble switch; the two cyc outputs are never both high.
- Pending count:
  - +1 on accept, -1 on downstream ack; simultaneous accept and ack leaves it unchanged.
  - Never wraps; full stalls, empty ignores stray acks.
- Returns:
  - o_wb_ack and o_wb_data are registered copies (1-cycle latency) of the active port's ack/data.
  - Acks from the inactive port are ignored.
- Errors:
  - An i_x_err on the active port raises o_wb_err for one cycle, drops all cyc/stb, clears pending, and enters ABORT.
  - ABORT returns to IDLE when !i_wb_cyc.
- CPU drops i_wb_cyc mid-burst: downstream cyc/stb drop next cycle, pending clears, state goes to IDLE, and no ack or err is returned.
- o_wb_ack and o_wb_err are forced 0 whenever i_wb_cyc is low.

Optional Feature:
- Macro: WBROUTER_TIMEOUT_EN.
- Defined:
  - A LGTIMEOUT-bit counter resets on any accept or ack while pending != 0.
  - On saturation it behaves exactly like i_x_err: o_wb_err pulse, then ABORT.
- Undefined: no counter; a hung slave stalls forever.

Decomposition:
- Shared package wb_router_pkg holds:
  - the state encoding (IDLE=2'b00, CBUS=2'b01, UBUS=2'b10, ABORT=2'b11);
  - default MEM_ADDR and MEM_MASK constants.
- One natural sub-module: the existing combinational iscachable instance, used for classification.
- Everything else is kept flat.

Test Plan:
- Reads to 0x4000000 and 0x4000001 with no stalls -> o_c_stb on the two following cycles, o_u_cyc stays 0; two o_wb_ack, each 1 cycle after i_c_ack, carrying data 0xDEADBEEF and 0x12345678.
- Read at 0x4000000, then read at 0x1000000 while the C ack is pending -> o_wb_stall=1 until the ack returns; same cycle o_c_cyc falls and o_u_cyc rises; o_c_cyc and o_u_cyc never both 1.
- 15 accepted requests with acks withheld (LGPEND=4) -> o_wb_stall=1 on the 16th; one ack -> stall drops and the count returns to 15 after the next accept.
- i_u_err asserted on the 2nd of 3 pending reads -> single o_wb_err pulse, o_u_cyc drops next cycle, later i_u_ack ignored, stall=1 until i_wb_cyc is released.
- i_reset asserted mid-burst with pending=3 -> all outputs 0 immediately (asynchronous); new burst after release starts with pending=0.
- With WBROUTER_TIMEOUT_EN and LGTIMEOUT=4: one read, no ack for 16 cycles -> o_wb_err pulse, state ABORT.

Source files
------------

// File: rtl/wb_router_pkg.sv
// Shared definitions for wb_cache_router: FSM state encoding and the
// default cachable-region constants.
package wb_router_pkg;

    // Bus-ownership state of the router
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StCbus  = 2'b01,
        StUbus  = 2'b10,
        StAbort = 2'b11
    } router_state_e;

    // Top nibble of the default cachable base and mask; lower bits are zero
    localparam logic [3:0] MEM_ADDR_TOP = 4'b0100;
    localparam logic [3:0] MEM_MASK_TOP = 4'b1111;

endpackage

// File: rtl/wb_cache_router_iscachable.sv
// Combinational cachable-region classifier, same rule as the dcache.
// A zero base address disables caching entirely.
module wb_cache_router_iscachable
    import wb_router_pkg::*;
#(
    parameter int unsigned   AW       = 28,
    parameter logic [AW-1:0] MEM_ADDR = {MEM_ADDR_TOP, {(AW-4){1'b0}}},
    parameter logic [AW-1:0] MEM_MASK = {MEM_MASK_TOP, {(AW-4){1'b0}}}
) (
    input  logic [AW-1:0] addr,
    output logic          cachable
);

    assign cachable = (MEM_ADDR != '0) && ((addr & MEM_MASK) == MEM_ADDR);

endmodule

// File: rtl/wb_cache_router.sv
// wb_cache_router: steers pipelined Wishbone requests from the CPU memory unit
// to the cachable memory port (C) or the uncached peripheral port (U), keeping
// returns in order by draining one port before switching to the other.
// Optional macro WBROUTER_TIMEOUT_EN: abort a burst whose slave stops responding.
module wb_cache_router
    import wb_router_pkg::*;
#(
    parameter int unsigned   AW        = 28,
    parameter int unsigned   DW        = 32,
    parameter logic [AW-1:0] MEM_ADDR  = {MEM_ADDR_TOP, {(AW-4){1'b0}}},
    parameter logic [AW-1:0] MEM_MASK  = {MEM_MASK_TOP, {(AW-4){1'b0}}},
    parameter int unsigned   LGPEND    = 4,
    parameter int unsigned   LGTIMEOUT = 10
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_addr,
    input  logic [DW-1:0]   i_wb_data,
    input  logic [DW/8-1:0] i_wb_sel,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_wb_err,
    output logic [DW-1:0]   o_wb_data,
    output logic            o_c_cyc,
    output logic            o_c_stb,
    output logic            o_u_cyc,
    output logic            o_u_stb,
    output logic            o_we,
    output logic [AW-1:0]   o_addr,
    output logic [DW-1:0]   o_data,
    output logic [DW/8-1:0] o_sel,
    input  logic            i_c_stall,
    input  logic            i_c_ack,
    input  logic            i_c_err,
    input  logic [DW-1:0]   i_c_data,
    input  logic            i_u_stall,
    input  logic            i_u_ack,
    input  logic            i_u_err,
    input  logic [DW-1:0]   i_u_data
);

    router_state_e     state_q, state_d;
    logic [LGPEND-1:0] pending_q, pending_d;

    logic              c_stb_q, u_stb_q, we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q, rdata_q;
    logic [DW/8-1:0]   sel_q;
    logic              ack_q, err_q;

    logic              cachable;
    logic              active_c, active_u;
    logic              stall, accept, drop;
    logic              port_ack, ack_ok, port_err, timeout;
    logic [DW-1:0]     port_data;

    wb_cache_router_iscachable #(
        .AW       (AW),
        .MEM_ADDR (MEM_ADDR),
        .MEM_MASK (MEM_MASK)
    ) u_iscachable (
        .addr     (i_wb_addr),
        .cachable (cachable)
    );

    assign active_c = (state_q == StCbus);
    assign active_u = (state_q == StUbus);
    assign drop     = !i_wb_cyc;

    // A new request must wait while the other port still owes us returns
    assign stall = (c_stb_q && i_c_stall) || (u_stb_q && i_u_stall)
                || (pending_q == '1)
                || ((pending_q != '0) && ((active_c && !cachable) || (active_u && cachable)))
                || (state_q == StAbort);

    assign accept    = i_wb_cyc && i_wb_stb && !stall;
    assign port_ack  = (active_c && i_c_ack) || (active_u && i_u_ack);
    assign port_data = active_u ? i_u_data : i_c_data;
    // Stray acks with nothing outstanding are dropped
    assign ack_ok    = port_ack && (pending_q != '0);
    assign port_err  = (active_c && i_c_err) || (active_u && i_u_err) || timeout;

`ifdef WBROUTER_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] tmo_q;
    logic                 busy;

    assign busy    = (active_c || active_u) && (pending_q != '0);
    assign timeout = busy && (&tmo_q);

    // Count cycles without progress while requests are outstanding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tmo_q <= '0;
        end else if (!busy || accept || ack_ok) begin
            tmo_q <= '0;
        end else if (!(&tmo_q)) begin
            tmo_q <= tmo_q + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
        end
    end
`else
    logic [31:0] unused_lgtimeout;

    assign unused_lgtimeout = LGTIMEOUT;
    assign timeout          = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: CPU release beats error beats a new request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = cachable ? StCbus : StUbus;
            end
            StCbus, StUbus: begin
                if (drop) begin
                    state_d = StIdle;
                end else if (port_err) begin
                    state_d = StAbort;
                end else if (accept) begin
                    state_d = cachable ? StCbus : StUbus;
                end
            end
            StAbort: begin
                if (drop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_c_cyc    = active_c;
        o_u_cyc    = active_u;
        o_wb_stall = stall;
        o_wb_ack   = ack_q && i_wb_cyc;
        o_wb_err   = err_q && i_wb_cyc;
        o_wb_data  = rdata_q;
        o_c_stb    = c_stb_q;
        o_u_stb    = u_stb_q;
        o_we       = we_q;
        o_addr     = addr_q;
        o_data     = wdata_q;
        o_sel      = sel_q;
    end

    // Outstanding-request count: saturates by stalling, never wraps
    always_comb begin
        pending_d = pending_q;
        if (drop || port_err) begin
            pending_d = '0;
        end else if (accept && !ack_ok) begin
            pending_d = pending_q + {{(LGPEND-1){1'b0}}, 1'b1};
        end else if (!accept && ack_ok) begin
            pending_d = pending_q - {{(LGPEND-1){1'b0}}, 1'b1};
        end
    end

    // Pending count, downstream request and CPU return registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pending_q <= '0;
            c_stb_q   <= 1'b0;
            u_stb_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ack_q     <= ack_ok && i_wb_cyc && !port_err;
            err_q     <= port_err && i_wb_cyc;
            if (ack_ok) rdata_q <= port_data;

            if (drop || port_err) begin
                c_stb_q <= 1'b0;
                u_stb_q <= 1'b0;
            end else if (accept) begin
                c_stb_q <= cachable;
                u_stb_q <= !cachable;
                we_q    <= i_wb_we;
                addr_q  <= i_wb_addr;
                wdata_q <= i_wb_data;
                sel_q   <= i_wb_sel;
            end else begin
                if (!i_c_stall) c_stb_q <= 1'b0;
                if (!i_u_stall) u_stb_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_cache_router.sv
// Directed self-checking bench for wb_cache_router (AW=28, DW=32, LGPEND=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_wb_cache_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        o_wb_stall, o_wb_ack, o_wb_err;
    logic [31:0] o_wb_data;
    logic        o_c_cyc, o_c_stb, o_u_cyc, o_u_stb, o_we;
    logic [27:0] o_addr;
    logic [31:0] o_data;
    logic [3:0]  o_sel;
    logic        c_stall, c_ack, c_err;
    logic [31:0] c_rdata;
    logic        u_stall, u_ack, u_err;
    logic [31:0] u_rdata;

    int          n_cmp, n_fail;
    logic        both_cyc_seen = 1'b0;

    always #5 clk = ~clk;

    wb_cache_router #(
        .AW        (28),
        .DW        (32),
        .LGPEND    (4),
        .LGTIMEOUT (4)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdata),
        .i_wb_sel   (sel),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_wb_err   (o_wb_err),
        .o_wb_data  (o_wb_data),
        .o_c_cyc    (o_c_cyc),
        .o_c_stb    (o_c_stb),
        .o_u_cyc    (o_u_cyc),
        .o_u_stb    (o_u_stb),
        .o_we       (o_we),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_sel      (o_sel),
        .i_c_stall  (c_stall),
        .i_c_ack    (c_ack),
        .i_c_err    (c_err),
        .i_c_data   (c_rdata),
        .i_u_stall  (u_stall),
        .i_u_ack    (u_ack),
        .i_u_err    (u_err),
        .i_u_data   (u_rdata)
    );

    // The two downstream cycles must never overlap
    always @(negedge clk) begin
        if (o_c_cyc && o_u_cyc) both_cyc_seen <= 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({o_wb_stall, o_wb_ack, o_wb_err, o_c_cyc, o_c_stb, o_u_cyc, o_u_stb, o_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {o_wb_stall, o_wb_ack, o_wb_err, o_c_cyc, o_c_stb, o_u_cyc, o_u_stb, o_we});
        end
        n_cmp++;
        if ({o_addr, o_data, o_sel, o_wb_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h data %h sel %h rdata %h want all 0",
                     o_addr, o_data, o_sel, o_wb_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick;
        n_cmp++;
        if ({o_wb_stall, o_c_cyc, o_u_cyc} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset: got %b want 000", {o_wb_stall, o_c_cyc, o_u_cyc});
        end
    endtask

    task automatic test_cached_reads;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf; wdata = '0;
        addr = 28'h4000000;
        #1;
        n_cmp++;
        if (o_wb_stall !== 1'b0) begin
            n_fail++; $display("FAIL rd_stall0: got %b want 0", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_c_cyc, o_c_stb, o_u_cyc, o_addr} !== {3'b110, 28'h4000000}) begin
            n_fail++;
            $display("FAIL rd_first: cyc/stb/ucyc %b addr %h want 110 4000000",
                     {o_c_cyc, o_c_stb, o_u_cyc}, o_addr);
        end
        addr = 28'h4000001;
        #1;
        n_cmp++;
        if (o_wb_stall !== 1'b0) begin
            n_fail++; $display("FAIL rd_stall1: got %b want 0", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_c_stb, o_u_cyc, o_addr} !== {2'b10, 28'h4000001}) begin
            n_fail++;
            $display("FAIL rd_second: stb/ucyc %b addr %h want 10 4000001",
                     {o_c_stb, o_u_cyc}, o_addr);
        end
        stb = 1'b0; c_ack = 1'b1; c_rdata = 32'hDEADBEEF;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_c_stb, o_wb_data} !== {2'b10, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rd_ack1: ack/stb %b data %h want 10 deadbeef",
                     {o_wb_ack, o_c_stb}, o_wb_data);
        end
        c_rdata = 32'h12345678;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_wb_data} !== {1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL rd_ack2: ack %b data %h want 1 12345678", o_wb_ack, o_wb_data);
        end
        c_ack = 1'b0;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_u_cyc, o_c_cyc} !== 3'b001) begin
            n_fail++;
            $display("FAIL rd_done: ack/ucyc/ccyc %b want 001", {o_wb_ack, o_u_cyc, o_c_cyc});
        end
        cyc = 1'b0;
        tick;
        n_cmp++;
        if (o_c_cyc !== 1'b0) begin
            n_fail++; $display("FAIL rd_release: c_cyc %b want 0", o_c_cyc);
        end
    endtask

    task automatic test_port_switch;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 28'h4000000;
        tick;
        addr = 28'h1000000; we = 1'b1; wdata = 32'hA5A5A5A5; sel = 4'h3;
        #1;
        n_cmp++;
        if (o_wb_stall !== 1'b1) begin
            n_fail++; $display("FAIL sw_stall_a: got %b want 1", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_wb_stall, o_c_cyc, o_u_cyc} !== 3'b110) begin
            n_fail++;
            $display("FAIL sw_hold: stall/ccyc/ucyc %b want 110", {o_wb_stall, o_c_cyc, o_u_cyc});
        end
        c_ack = 1'b1; c_rdata = 32'h00C0FFEE;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_wb_stall, o_c_cyc} !== 3'b101) begin
            n_fail++;
            $display("FAIL sw_ack: ack/stall/ccyc %b want 101", {o_wb_ack, o_wb_stall, o_c_cyc});
        end
        c_ack = 1'b0;
        tick;
        n_cmp++;
        if ({o_c_cyc, o_u_cyc, o_u_stb, o_we, o_addr, o_data, o_sel}
                !== {4'b0111, 28'h1000000, 32'hA5A5A5A5, 4'h3}) begin
            n_fail++;
            $display("FAIL sw_switch: ccyc/ucyc/ustb/we %b addr %h data %h sel %h",
                     {o_c_cyc, o_u_cyc, o_u_stb, o_we}, o_addr, o_data, o_sel);
        end
        stb = 1'b0; we = 1'b0; u_ack = 1'b1; u_rdata = 32'hCAFEF00D;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_wb_data} !== {1'b1, 32'hCAFEF00D}) begin
            n_fail++; $display("FAIL sw_uack: ack %b data %h want 1 cafef00d", o_wb_ack, o_wb_data);
        end
        u_ack = 1'b0; cyc = 1'b0;
        tick;
        n_cmp++;
        if (both_cyc_seen !== 1'b0) begin
            n_fail++; $display("FAIL sw_overlap: both cyc seen %b want 0", both_cyc_seen);
        end
    endtask

    task automatic test_pend_full;
        int stalls_seen = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            addr = 28'h4000000 + 28'(i);
            #1;
            if (o_wb_stall) stalls_seen++;
            tick;
        end
        n_cmp++;
        if (stalls_seen !== 0) begin
            n_fail++; $display("FAIL pf_fill: stalled %0d times want 0", stalls_seen);
        end
        n_cmp++;
        if (o_wb_stall !== 1'b1) begin
            n_fail++; $display("FAIL pf_full: stall %b want 1", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_wb_stall, o_c_stb} !== 2'b10) begin
            n_fail++; $display("FAIL pf_16th: stall/stb %b want 10", {o_wb_stall, o_c_stb});
        end
        c_ack = 1'b1; c_rdata = 32'h0000FFFF;
        tick;
        n_cmp++;
        if ({o_wb_stall, o_wb_ack} !== 2'b01) begin
            n_fail++; $display("FAIL pf_drain: stall/ack %b want 01", {o_wb_stall, o_wb_ack});
        end
        c_ack = 1'b0;
        tick;
        n_cmp++;
        if ({o_wb_stall, o_c_stb} !== 2'b11) begin
            n_fail++; $display("FAIL pf_refill: stall/stb %b want 11", {o_wb_stall, o_c_stb});
        end
        stb = 1'b0; cyc = 1'b0;
        tick;
        n_cmp++;
        if ({o_c_cyc, o_c_stb, o_wb_stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL pf_release: ccyc/stb/stall %b want 000", {o_c_cyc, o_c_stb, o_wb_stall});
        end
    endtask

    task automatic test_error;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = 28'h1000000 + 28'(i);
            tick;
        end
        stb = 1'b0; u_ack = 1'b1; u_rdata = 32'h11111111;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_u_cyc} !== 2'b11) begin
            n_fail++; $display("FAIL er_ack1: ack/ucyc %b want 11", {o_wb_ack, o_u_cyc});
        end
        u_ack = 1'b0; u_err = 1'b1;
        tick;
        n_cmp++;
        if ({o_wb_err, o_u_cyc, o_u_stb, o_wb_stall} !== 4'b1001) begin
            n_fail++;
            $display("FAIL er_pulse: err/ucyc/ustb/stall %b want 1001",
                     {o_wb_err, o_u_cyc, o_u_stb, o_wb_stall});
        end
        u_err = 1'b0; u_ack = 1'b1; u_rdata = 32'h22222222;
        tick;
        n_cmp++;
        if ({o_wb_err, o_wb_ack, o_wb_stall} !== 3'b001) begin
            n_fail++;
            $display("FAIL er_after: err/ack/stall %b want 001", {o_wb_err, o_wb_ack, o_wb_stall});
        end
        u_ack = 1'b0; stb = 1'b1; addr = 28'h4000000;
        tick;
        n_cmp++;
        if ({o_wb_stall, o_c_cyc, o_u_cyc} !== 3'b100) begin
            n_fail++;
            $display("FAIL er_abort: stall/ccyc/ucyc %b want 100", {o_wb_stall, o_c_cyc, o_u_cyc});
        end
        stb = 1'b0; cyc = 1'b0;
        tick;
        n_cmp++;
        if ({o_wb_stall, o_wb_err} !== 2'b00) begin
            n_fail++; $display("FAIL er_release: stall/err %b want 00", {o_wb_stall, o_wb_err});
        end
    endtask

    task automatic test_cpu_drop;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 28'h4000010;
        tick;
        addr = 28'h4000011;
        tick;
        stb = 1'b0; cyc = 1'b0; c_ack = 1'b1; c_rdata = 32'h33333333;
        #1;
        n_cmp++;
        if ({o_wb_ack, o_wb_err} !== 2'b00) begin
            n_fail++; $display("FAIL dr_force: ack/err %b want 00", {o_wb_ack, o_wb_err});
        end
        tick;
        n_cmp++;
        if ({o_c_cyc, o_c_stb, o_wb_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL dr_drop: ccyc/stb/ack %b want 000", {o_c_cyc, o_c_stb, o_wb_ack});
        end
        c_ack = 1'b0; cyc = 1'b1; stb = 1'b1; addr = 28'h1000020;
        #1;
        n_cmp++;
        if (o_wb_stall !== 1'b0) begin
            n_fail++; $display("FAIL dr_cleared: stall %b want 0", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_u_cyc, o_c_cyc} !== 2'b10) begin
            n_fail++; $display("FAIL dr_new: ucyc/ccyc %b want 10", {o_u_cyc, o_c_cyc});
        end
        stb = 1'b0; u_ack = 1'b1;
        tick;
        u_ack = 1'b0; cyc = 1'b0;
        tick;
    endtask

    task automatic test_reset_midburst;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = 28'h4000020 + 28'(i);
            tick;
        end
        stb = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_wb_stall, o_wb_ack, o_wb_err, o_c_cyc, o_c_stb, o_u_cyc, o_u_stb, o_we} !== 8'h00) begin
            n_fail++;
            $display("FAIL rm_async: got %b want 00000000",
                     {o_wb_stall, o_wb_ack, o_wb_err, o_c_cyc, o_c_stb, o_u_cyc, o_u_stb, o_we});
        end
        n_cmp++;
        if (o_addr !== 28'h0) begin
            n_fail++; $display("FAIL rm_addr: got %h want 0", o_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stb = 1'b1; addr = 28'h4000030;
        tick;
        stb = 1'b0; c_ack = 1'b1; c_rdata = 32'h0BADF00D;
        tick;
        n_cmp++;
        if ({o_wb_ack, o_wb_data} !== {1'b1, 32'h0BADF00D}) begin
            n_fail++; $display("FAIL rm_ack: ack %b data %h want 1 0badf00d", o_wb_ack, o_wb_data);
        end
        c_ack = 1'b0; stb = 1'b1; addr = 28'h1000030;
        #1;
        n_cmp++;
        if (o_wb_stall !== 1'b0) begin
            n_fail++; $display("FAIL rm_pending0: stall %b want 0", o_wb_stall);
        end
        tick;
        n_cmp++;
        if ({o_u_cyc, o_c_cyc} !== 2'b10) begin
            n_fail++; $display("FAIL rm_switch: ucyc/ccyc %b want 10", {o_u_cyc, o_c_cyc});
        end
        stb = 1'b0; u_ack = 1'b1;
        tick;
        u_ack = 1'b0; cyc = 1'b0;
        tick;
    endtask

`ifdef WBROUTER_TIMEOUT_EN
    task automatic test_timeout;
        logic seen = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 28'h4000040;
        tick;
        stb = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick;
            if (o_wb_err) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL to_err: err seen %b want 1", seen);
        end
        n_cmp++;
        if ({o_wb_stall, o_c_cyc} !== 2'b10) begin
            n_fail++; $display("FAIL to_abort: stall/ccyc %b want 10", {o_wb_stall, o_c_cyc});
        end
        cyc = 1'b0;
        tick;
    endtask
`endif

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
        c_stall = 1'b0; c_ack = 1'b0; c_err = 1'b0; c_rdata = '0;
        u_stall = 1'b0; u_ack = 1'b0; u_err = 1'b0; u_rdata = '0;
        test_reset;
        test_cached_reads;
        test_port_switch;
        test_pend_full;
        test_error;
        test_cpu_drop;
        test_reset_midburst;
`ifdef WBROUTER_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
